// File: rtl/proc_pkg.sv
// Shared definitions for the data RAM arbiter.
// Contents:
//   ADDR_W_DEF / DATA_W_DEF  default address and data widths
//   STARVE_LIMIT_DEF         default consecutive-CPU-grant limit
//   CTR_W                    width of the starvation streak counter
//   arb_state_e              arbiter FSM state encoding
//   OWNER_CPU / OWNER_DBG    owner flag encoding
package proc_pkg;

  localparam int ADDR_W_DEF       = 8;
  localparam int DATA_W_DEF       = 16;
  localparam int STARVE_LIMIT_DEF = 4;
  localparam int CTR_W            = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ACC  = 2'b01,
    ST_RD   = 2'b10
  } arb_state_e;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_DBG = 1'b1;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating streak counter for the DBG starvation guard.
// Ports:
//   clock     system clock, rising edge
//   reset     asynchronous active-high reset
//   clr       clear the streak (has priority over inc)
//   inc       count one CPU grant taken while DBG was waiting
//   at_limit  streak has reached LIMIT; DBG must win the next arbitration
module arb_starve_ctr
  import proc_pkg::*;
#(
  parameter int LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic at_limit
);

  logic [CTR_W-1:0] count;

  assign at_limit = (count == CTR_W'(LIMIT));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !at_limit) begin
      count <= count + CTR_W'(1);
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbiter sharing the single-port data RAM between the CPU port and the
// host debug/loader port. CPU has fixed priority; DBG is forced through
// after STARVE_LIMIT consecutive CPU grants taken while it was waiting.
// Ports:
//   clock, reset                          clock / async active-high reset
//   cpu_req/wr/addr/wdata                 CPU request (held until cpu_gnt)
//   cpu_gnt, cpu_done, cpu_rdata          CPU accept pulse, completion pulse, read data
//   dbg_req/wr/addr/wdata                 DBG request (held until dbg_gnt)
//   dbg_gnt, dbg_done, dbg_rdata          DBG accept pulse, completion pulse, read data
//   m_addr, m_wr, m_wdata                 registered RAM controls
//   m_rdata                               RAM read data, one cycle after m_addr
//   busy                                  access in progress
//   owner                                 0=CPU, 1=DBG, current/last access
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | no access; arbitrate on the requests sampled this edge
// ST_ACC  | m_* presented to the RAM; m_wr high for a write
// ST_RD   | m_rdata valid; captured into the owner's rdata at the edge
module data_mem_arbiter
  import proc_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_wr,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_done,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_wr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy,
  output logic              owner
);

  arb_state_e state, state_nxt;

  logic grant_cpu, grant_dbg;
  logic done_cpu_nxt, done_dbg_nxt;
  logic cap_rd;
  logic m_wr_nxt;
  logic ctr_clr, ctr_inc, at_limit;

  arb_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_ctr (
    .clock    (clock),
    .reset    (reset),
    .clr      (ctr_clr),
    .inc      (ctr_inc),
    .at_limit (at_limit)
  );

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    grant_cpu    = 1'b0;
    grant_dbg    = 1'b0;
    done_cpu_nxt = 1'b0;
    done_dbg_nxt = 1'b0;
    cap_rd       = 1'b0;
    m_wr_nxt     = 1'b0;
    ctr_clr      = 1'b0;
    ctr_inc      = 1'b0;
    case (state)
      ST_IDLE: begin
        // A DBG that stops waiting forfeits its accumulated streak.
        ctr_clr = !dbg_req;
        if (dbg_req && (!cpu_req || at_limit)) begin
          grant_dbg = 1'b1;
          ctr_clr   = 1'b1;
          m_wr_nxt  = dbg_wr;
          state_nxt = ST_ACC;
        end else if (cpu_req) begin
          grant_cpu = 1'b1;
          ctr_inc   = dbg_req;
          m_wr_nxt  = cpu_wr;
          state_nxt = ST_ACC;
        end
      end
      ST_ACC: begin
        // m_wr is high here exactly when the current access is a write.
        if (m_wr) begin
          done_cpu_nxt = (owner == OWNER_CPU);
          done_dbg_nxt = (owner == OWNER_DBG);
          state_nxt    = ST_IDLE;
        end else begin
          state_nxt = ST_RD;
        end
      end
      ST_RD: begin
        cap_rd       = 1'b1;
        done_cpu_nxt = (owner == OWNER_CPU);
        done_dbg_nxt = (owner == OWNER_DBG);
        state_nxt    = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cpu_gnt   <= 1'b0;
      dbg_gnt   <= 1'b0;
      cpu_done  <= 1'b0;
      dbg_done  <= 1'b0;
      cpu_rdata <= '0;
      dbg_rdata <= '0;
      m_addr    <= '0;
      m_wr      <= 1'b0;
      m_wdata   <= '0;
      owner     <= OWNER_CPU;
    end else begin
      cpu_gnt  <= grant_cpu;
      dbg_gnt  <= grant_dbg;
      cpu_done <= done_cpu_nxt;
      dbg_done <= done_dbg_nxt;
      m_wr     <= m_wr_nxt;
      if (grant_dbg) begin
        m_addr  <= dbg_addr;
        m_wdata <= dbg_wdata;
        owner   <= OWNER_DBG;
      end else if (grant_cpu) begin
        m_addr  <= cpu_addr;
        m_wdata <= cpu_wdata;
        owner   <= OWNER_CPU;
      end
      if (cap_rd && (owner == OWNER_CPU)) begin
        cpu_rdata <= m_rdata;
      end
      if (cap_rd && (owner == OWNER_DBG)) begin
        dbg_rdata <= m_rdata;
      end
    end
  end

endmodule
